// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//   - load_e / store_e : funct3 encodings for loads and stores
//   - WbSel*           : writeback-select encodings carried through MEM/WB
//   - store_be()       : byte-enable pattern for a store of a given size and offset
package mem_pkg;

    typedef enum logic [2:0] {
        LdB  = 3'b000,
        LdH  = 3'b001,
        LdW  = 3'b010,
        LdBu = 3'b100,
        LdHu = 3'b101
    } load_e;

    typedef enum logic [2:0] {
        StB = 3'b000,
        StH = 3'b001,
        StW = 3'b010
    } store_e;

    localparam logic [1:0] WbSelAlu = 2'd0;
    localparam logic [1:0] WbSelMem = 2'd1;
    localparam logic [1:0] WbSelPc4 = 2'd2;

    // Halfword lane pair is chosen by off[1]; word ignores off entirely.
    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3)
            StB:     be = 4'b0001 << off;
            StH:     be = off[1] ? 4'b1100 : 4'b0011;
            StW:     be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem.sv
// Byte-enabled synchronous single-port data RAM.
//   clk_i   : clock, rising edge
//   rst_ni  : async active-low reset (clears the read register only)
//   we_i    : per-byte write enables, already gated by reset/stall upstream
//   addr_i  : word index
//   wdata_i : write data (lane-replicated by the caller)
//   hold_i  : freeze the read register
//   rdata_o : registered read word
module dmem
    import mem_pkg::*;
#(
    parameter int unsigned Depth = 2048,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [3:0]    we_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic          hold_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (!hold_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: performs loads/stores against a local data RAM and
// registers the MEM/WB boundary. Load data is aligned and extended before leaving.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds o_misaligned, suppresses
// misaligned stores, clears o_regwen on misaligned loads).
// Ports:
//   i_clk, i_reset (async active-low), i_stall (hold outputs, block store commit)
//   i_pc/i_inst/i_alu/i_rs2 : EX/MEM operands; i_alu is the effective address
//   i_memrw (store), i_load_type (load funct3), i_wb_sel, i_regwen
//   o_pc/o_inst/o_alu/o_wb_sel/o_regwen : registered passthrough
//   o_ld_data : aligned, extended load data; o_misaligned (feature only)
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_rs2,
    input  logic        i_memrw,
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_regwen,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_alu,
    output logic [31:0] o_ld_data,
    output logic [1:0]  o_wb_sel,
    output logic        o_regwen
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        o_misaligned
`endif
);

    logic [1:0]  off;
    logic [2:0]  st_f3;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misaligned;

    logic [31:0] pc_q, pc_d, inst_q, inst_d, alu_q, alu_d;
    logic [1:0]  wb_sel_q, wb_sel_d, off_q, off_d;
    logic [2:0]  ltype_q, ltype_d;
    logic        regwen_q, regwen_d, misaligned_q, misaligned_d;

    assign off   = i_alu[1:0];
    assign st_f3 = i_inst[14:12];

    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (i_memrw) begin
            misaligned = ((st_f3 == StH) && off[0]) || ((st_f3 == StW) && (off != 2'b00));
        end else if (i_wb_sel == WbSelMem) begin
            misaligned = (((i_load_type == LdH) || (i_load_type == LdHu)) && off[0]) ||
                         ((i_load_type == LdW) && (off != 2'b00));
        end
`endif
    end

    always_comb begin
        be = '0;
        if (i_memrw && !i_stall && i_reset && !misaligned) begin
            be = store_be(st_f3, off);
        end
        case (st_f3)
            StB:     wdata = {4{i_rs2[7:0]}};
            StH:     wdata = {2{i_rs2[15:0]}};
            default: wdata = i_rs2;
        endcase
    end

    dmem #(
        .Depth (DEPTH_WORDS),
        .Aw    (AW)
    ) u_dmem (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .we_i    (be),
        .addr_i  (i_alu[AW+1:2]),
        .wdata_i (wdata),
        .hold_i  (i_stall),
        .rdata_o (rdata)
    );

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        alu_d        = alu_q;
        wb_sel_d     = wb_sel_q;
        regwen_d     = regwen_q;
        off_d        = off_q;
        ltype_d      = ltype_q;
        misaligned_d = misaligned_q;
        if (!i_stall) begin
            pc_d         = i_pc;
            inst_d       = i_inst;
            alu_d        = i_alu;
            wb_sel_d     = i_wb_sel;
            // A trapped load must not write the register file.
            regwen_d     = i_regwen && !(misaligned && !i_memrw);
            off_d        = off;
            ltype_d      = i_load_type;
            misaligned_d = misaligned;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q         <= '0;
            inst_q       <= '0;
            alu_q        <= '0;
            wb_sel_q     <= '0;
            regwen_q     <= 1'b0;
            off_q        <= '0;
            ltype_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            alu_q        <= alu_d;
            wb_sel_q     <= wb_sel_d;
            regwen_q     <= regwen_d;
            off_q        <= off_d;
            ltype_q      <= ltype_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Extraction works on the registered word so it lines up with the other outputs.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? rdata[31:16] : rdata[15:0];
        case (ltype_q)
            LdB:     o_ld_data = {{24{ld_byte[7]}}, ld_byte};
            LdH:     o_ld_data = {{16{ld_half[15]}}, ld_half};
            LdW:     o_ld_data = rdata;
            LdBu:    o_ld_data = {24'd0, ld_byte};
            LdHu:    o_ld_data = {16'd0, ld_half};
            default: o_ld_data = '0;
        endcase
    end

    assign o_pc     = pc_q;
    assign o_inst   = inst_q;
    assign o_alu    = alu_q;
    assign o_wb_sel = wb_sel_q;
    assign o_regwen = regwen_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign o_misaligned = misaligned_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc, inst, alu, rs2;
    logic        memrw;
    logic [2:0]  load_type;
    logic [1:0]  wb_sel;
    logic        regwen;
    logic [31:0] o_pc, o_inst, o_alu, o_ld_data;
    logic [1:0]  o_wb_sel;
    logic        o_regwen;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_stall     (stall),
        .i_pc        (pc),
        .i_inst      (inst),
        .i_alu       (alu),
        .i_rs2       (rs2),
        .i_memrw     (memrw),
        .i_load_type (load_type),
        .i_wb_sel    (wb_sel),
        .i_regwen    (regwen),
        .o_pc        (o_pc),
        .o_inst      (o_inst),
        .o_alu       (o_alu),
        .o_ld_data   (o_ld_data),
        .o_wb_sel    (o_wb_sel),
        .o_regwen    (o_regwen)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .o_misaligned(o_misaligned)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; loads use wb_sel=mem, stores/others wb_sel=alu.
    task automatic drive(input logic [31:0] p, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic st, input logic ld,
                         input logic rw);
        pc        = p;
        inst      = {17'd0, f3, 5'd1, st ? 7'h23 : 7'h03};
        alu       = a;
        rs2       = d;
        memrw     = st;
        load_type = f3;
        wb_sel    = ld ? 2'd1 : 2'd0;
        regwen    = rw;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        drive(32'h1000, f3, a, d, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        drive(32'h2000, f3, a, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        drive(32'h0000_0044, 3'b010, 32'h10, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        check_eq("rst_pc", o_pc, 32'h0);
        check_eq("rst_inst", o_inst, 32'h0);
        check_eq("rst_alu", o_alu, 32'h0);
        check_eq("rst_ld", o_ld_data, 32'h0);
        check_eq("rst_wbsel", {30'd0, o_wb_sel}, 32'h0);
        check_eq("rst_regwen", {31'd0, o_regwen}, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check_eq("rst_misal", {31'd0, o_misaligned}, 32'h0);
`endif
        rst_n = 1'b1;
        drive(32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        load(3'b010, 32'h10);
        check_eq("rst_no_store", {31'd0, o_ld_data == 32'h1234_5678}, 32'h0);

        // Word store then every load flavour.
        drive(32'h0000_0100, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("pass_pc", o_pc, 32'h100);
        check_eq("pass_alu", o_alu, 32'h100);
        check_eq("pass_inst", o_inst, {17'd0, 3'b010, 5'd1, 7'h23});
        load(3'b000, 32'h103); check_eq("lb_103", o_ld_data, 32'hFFFF_FFDE);
        check_eq("ld_wbsel", {30'd0, o_wb_sel}, 32'h1);
        check_eq("ld_regwen", {31'd0, o_regwen}, 32'h1);
        load(3'b100, 32'h103); check_eq("lbu_103", o_ld_data, 32'h0000_00DE);
        load(3'b001, 32'h102); check_eq("lh_102", o_ld_data, 32'hFFFF_DEAD);
        load(3'b101, 32'h102); check_eq("lhu_102", o_ld_data, 32'h0000_DEAD);
        load(3'b010, 32'h100); check_eq("lw_100", o_ld_data, 32'hDEAD_BEEF);
        load(3'b000, 32'h101); check_eq("lb_101", o_ld_data, 32'hFFFF_FFBE);
        load(3'b100, 32'h100); check_eq("lbu_100", o_ld_data, 32'h0000_00EF);
        load(3'b001, 32'h100); check_eq("lh_100", o_ld_data, 32'hFFFF_BEEF);
        load(3'b011, 32'h100); check_eq("ld_bad_f3", o_ld_data, 32'h0);

        // Partial stores leave other lanes untouched.
        store(3'b010, 32'h100, 32'h1122_3344);
        store(3'b000, 32'h101, 32'hFFFF_FF5A);
        load(3'b010, 32'h100); check_eq("sb_101", o_ld_data, 32'h1122_5A44);
        store(3'b001, 32'h102, 32'hAAAA_7788);
        load(3'b010, 32'h100); check_eq("sh_102", o_ld_data, 32'h7788_5A44);
        store(3'b011, 32'h100, 32'h0);
        load(3'b010, 32'h100); check_eq("st_bad_f3", o_ld_data, 32'h7788_5A44);

        // Store immediately followed by load of the same word.
        store(3'b010, 32'h200, 32'hCAFE_F00D);
        load(3'b010, 32'h200); check_eq("b2b_sw_lw", o_ld_data, 32'hCAFE_F00D);

        // Stall: outputs frozen and store not committed while held.
        store(3'b010, 32'h300, 32'h0101_0101);
        drive(32'h40, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h44, 3'b010, 32'h300, 32'hABCD_1234, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("stall_pc%0d", i), o_pc, 32'h40);
            check_eq($sformatf("stall_ld%0d", i), o_ld_data, 32'h7788_5A44);
        end
        stall = 1'b0;
        load(3'b010, 32'h300); check_eq("stall_no_commit", o_ld_data, 32'h0101_0101);
        drive(32'h48, 3'b010, 32'h300, 32'hABCD_1234, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        check_eq("stall_release_pc", o_pc, 32'h48);
        load(3'b010, 32'h300); check_eq("stall_commit", o_ld_data, 32'hABCD_1234);

        // Misaligned accesses.
        load(3'b010, 32'h102);
`ifdef MEM_MISALIGN_TRAP_EN
        check_eq("mis_lw_flag", {31'd0, o_misaligned}, 32'h1);
        check_eq("mis_lw_regwen", {31'd0, o_regwen}, 32'h0);
        load(3'b010, 32'h100);
        check_eq("al_lw_flag", {31'd0, o_misaligned}, 32'h0);
        check_eq("al_lw_regwen", {31'd0, o_regwen}, 32'h1);
        store(3'b010, 32'h102, 32'h9999_9999);
        check_eq("mis_sw_flag", {31'd0, o_misaligned}, 32'h1);
        load(3'b010, 32'h100); check_eq("mis_sw_supp", o_ld_data, 32'h7788_5A44);
`else
        check_eq("mis_lw_data", o_ld_data, 32'h7788_5A44);
        check_eq("mis_lw_regwen", {31'd0, o_regwen}, 32'h1);
        load(3'b101, 32'h101); check_eq("mis_lhu_101", o_ld_data, 32'h0000_5A44);
        store(3'b010, 32'h102, 32'h9999_9999);
        load(3'b010, 32'h100); check_eq("mis_sw_word", o_ld_data, 32'h9999_9999);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage.
- Consumes the EX/MEM pipeline-register outputs, performs loads and stores against a local byte-enabled synchronous data RAM, and registers the results as the MEM/WB boundary for writeback.
- Load data is aligned and sign- or zero-extended at the output, so writeback sees final 32-bit data.

Parameters:
- DEPTH_WORDS, 2048: data RAM depth in 32-bit words; power of 2.
- AW, $clog2(DEPTH_WORDS): word-index width, derived; used for address bits [AW+1:2].

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_stall  in  1  hold MEM/WB outputs; suppress store commit.
- i_pc  in  32  instruction PC.
- i_inst  in  32  instruction word; store size is taken from i_inst[14:12].
- i_alu  in  32  effective address, or ALU result passthrough.
- i_rs2  in  32  store data.
- i_memrw  in  1  1 = store, 0 = no store.
- i_load_type  in  3  funct3 load encoding.
- i_wb_sel  in  2  writeback select.
- i_regwen  in  1  register write enable.
- o_pc  out  32  registered PC.
- o_inst  out  32  registered instruction.
- o_alu  out  32  registered ALU result.
- o_ld_data  out  32  aligned, extended load data.
- o_wb_sel  out  2  registered writeback select.
- o_regwen  out  1  registered register write enable.
- o_misaligned  out  1  misaligned access flag; only present with MEM_MISALIGN_TRAP_EN.

Behaviour:
- Reset: asynchronous, active-low. While i_reset=0:
  - o_pc, o_inst, o_alu, o_ld_data, o_wb_sel, o_regwen, o_misaligned = 0.
  - RAM read register and registered byte-offset/load-type = 0.
  - RAM contents are not reset.
  - RAM write is gated by i_reset=1, so a store presented during reset never commits.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N, including o_ld_data.
- RAM:
  - Single port, word index = i_alu[AW+1:2]; addresses wrap modulo DEPTH_WORDS.
  - Read is synchronous every non-stalled cycle.
  - Write is synchronous with 4 byte-enables.
  - Only one access per cycle, so no read/write collision exists.
- Store (i_memrw=1, i_stall=0), with off = i_alu[1:0]:
  - funct3 000 SB: byte lane off, data = rs2[7:0] replicated to all lanes.
  - funct3 001 SH: lanes {off[1]*2 +1, +0}, data = rs2[15:0] replicated.
  - funct3 010 SW: all lanes, data = rs2.
  - Other funct3 values: no write.
- Load extraction (combinational from registered RAM word, registered off, registered load_type):
  - 000 LB: sign-extend byte at off.
  - 001 LH: sign-extend halfword at off[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte at off.
  - 101 LHU: zero-extend halfword at off[1].
  - Others: 0.
  - o_ld_data is driven regardless of o_wb_sel; writeback selects it.
- Stall (i_stall=1):
  - All output registers, the RAM read register, and the registered off/load_type hold their values.
  - Store is not committed; the upstream register holds it, so it commits once when the stall releases.
- Store followed by a load to the same word on the next cycle: the load returns the new data (write precedes that read edge).
- Passthrough: o_pc, o_inst, o_alu, o_wb_sel, o_regwen = registered inputs, except where the optional feature overrides o_regwen.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - A misaligned store is suppressed (no byte-enables).
  - A misaligned load registers o_regwen=0.
  - o_misaligned=1 for that instruction's output cycle, else 0.
- Undefined:
  - No o_misaligned port.
  - Low address bits beyond the access size are ignored (halfword uses off[1]; word forces off=0); accesses always complete.

Decomposition:
- Package mem_pkg:
  - Load funct3 enum: LB, LH, LW, LBU, LHU.
  - Store funct3 enum: SB, SH, SW.
  - wb_sel encoding constants.
  - Byte-enable helper function.
- Sub-module dmem:
  - Byte-enabled synchronous single-port RAM.
  - Ports: clk, reset-gated we[3:0], addr[AW-1:0], wdata, rdata registered, hold input for stall.

Test Plan:
- Reset: hold i_reset=0 with i_memrw=1 at addr 0x10 → all outputs 0; a later LW from 0x10 does not return the i_rs2 that was presented during reset.
- SW 0xDEADBEEF at 0x100, then LB/LBU/LH/LHU/LW at 0x103/0x103/0x102/0x102/0x100 → 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF.
- SB 0x5A at 0x101 over word 0x11223344 → LW 0x100 returns 0x11225A44; other lanes untouched.
- Back-to-back SW 0xCAFEF00D at 0x200, then LW 0x200 next cycle → o_ld_data=0xCAFEF00D after 1-cycle latency.
- i_stall=1 for 3 cycles during an SW to 0x300 → outputs frozen, RAM unchanged until release; store commits once.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 with i_regwen=1 → o_misaligned=1, o_regwen=0. Without it: same load returns the word at 0x100.
